// File: rtl/kgp_isa_pkg.sv
// KGPRISC instruction-field positions and fetch-entry types shared by the
// fetch/decode boundary logic.
package kgp_isa_pkg;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_entry_t;

  localparam int ENTRY_W = $bits(if_entry_t);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/kgp_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with a registered upstream ready
// and a synchronous clear that empties both entries.
module kgp_skid_buf
  import kgp_isa_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i
);

  occ_e         state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] skid_q, skid_d;
  logic         ready_q;
  logic         accept, consume;

  assign accept      = in_valid_i && ready_q;
  assign out_valid_o = (state_q != OCC_EMPTY);
  assign consume     = out_valid_o && out_ready_i;
  assign in_ready_o  = ready_q;
  assign out_data_o  = head_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (clr_i) begin
      // Entries are dropped but head data is left in place; it is don't-care once invalid.
      state_d = OCC_EMPTY;
    end else begin
      unique case (state_q)
        OCC_EMPTY: begin
          if (accept) begin
            state_d = OCC_ONE;
            head_d  = in_data_i;
          end
        end
        OCC_ONE: begin
          if (accept && consume) begin
            head_d = in_data_i;
          end else if (accept) begin
            state_d = OCC_FULL;
            skid_d  = in_data_i;
          end else if (consume) begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (consume) begin
            state_d = OCC_ONE;
            head_d  = skid_q;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      state_q <= OCC_EMPTY;
      ready_q <= 1'b1;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != OCC_FULL);
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/id_stage_reg.sv
// KGPRISC fetch-to-decode register: skid-buffered {pc, instr} with field slicing
// and flush. Optional stall counter enabled by defining ID_STALL_CNT_EN.
module id_stage_reg
  import kgp_isa_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  input  logic [DATA_W-1:0] if_instr,
  input  logic [DATA_W-1:0] if_pc,
  output logic              if_ready,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [DATA_W-1:0] id_pc,
  output logic [5:0]        id_opcode,
  output logic [4:0]        id_rs,
  output logic [4:0]        id_rt,
  output logic [5:0]        id_funct,
  output logic [IMM_W-1:0]  id_imm16
`ifdef ID_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  if_entry_t in_entry;
  if_entry_t head_entry;
  logic      unused_shamt;

  assign in_entry.pc    = if_pc;
  assign in_entry.instr = if_instr;

  kgp_skid_buf #(
    .W(ENTRY_W)
  ) u_skid (
    .clk         (clk),
    .rst_ni      (rst),
    .clr_i       (flush),
    .in_valid_i  (if_valid),
    .in_data_i   (in_entry),
    .in_ready_o  (if_ready),
    .out_valid_o (id_valid),
    .out_data_o  (head_entry),
    .out_ready_i (id_ready)
  );

  assign id_pc        = head_entry.pc;
  assign id_opcode    = head_entry.instr[OPC_HI:OPC_LO];
  assign id_rs        = head_entry.instr[RS_HI:RS_LO];
  assign id_rt        = head_entry.instr[RT_HI:RT_LO];
  assign id_funct     = head_entry.instr[FUNCT_HI:FUNCT_LO];
  assign id_imm16     = head_entry.instr[IMM_HI:IMM_LO];
  // Shift-amount bits are decoded elsewhere and not exposed here.
  assign unused_shamt = ^head_entry.instr[10:6];

`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    stall_d = stall_q;
    if (id_valid && !id_ready) stall_d = sat_inc(stall_q);
  end

  // Cleared by reset only; flush does not touch the statistic.
  always_ff @(posedge clk) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: doc/id_stage_reg.md
Name: id_stage_reg

Overview:
- Fetch-to-decode pipeline register for KGPRISC.
- Accepts a 32-bit instruction and its PC from fetch over a valid/ready handshake, then holds them in a 2-entry skid buffer.
- Presents the decoded fields to decode. id_imm16 drives the 16-bit input of the sign-extension stage directly.
- Full throughput with registered if_ready, so there is no combinational ready path back to fetch.

Parameters:
- DATA_W, 32, instruction and PC width.
- IMM_W, 16, immediate field width fed to sign extension.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-low
- flush  in  1  discard all buffered instructions (branch taken)
- if_valid  in  1  fetch presents an instruction
- if_instr  in  DATA_W  instruction word
- if_pc  in  DATA_W  PC of if_instr
- if_ready  out  1  buffer can accept; registered
- id_valid  out  1  decode outputs are valid
- id_ready  in  1  decode consumes the head entry
- id_pc  out  DATA_W  PC of head entry
- id_opcode  out  6  instr[31:26]
- id_rs  out  5  instr[25:21]
- id_rt  out  5  instr[20:16]
- id_funct  out  6  instr[5:0]
- id_imm16  out  IMM_W  instr[15:0], to sign extension
- stall_cnt  out  32  present only with ID_STALL_CNT_EN

Behaviour:
- Reset (rst low at a clk edge):
  - id_valid=0 and if_ready=1.
  - Both entries are invalid.
  - All id_* data outputs and stall_cnt are 0.
  - Reset asserted mid-operation drops all buffered entries.
- Accept occurs when if_valid && if_ready. Consume occurs when id_valid && id_ready.
- State machine, by occupancy:
  - EMPTY. Accept goes to ONE. The entry appears on id_* the next cycle, so latency is 1 cycle.
  - ONE:
    - accept and consume together stay in ONE; the head is replaced.
    - accept only goes to FULL; the new entry goes to the skid register.
    - consume only goes to EMPTY.
  - FULL. if_ready=0. Consume goes to ONE and the skid entry moves to head.
- if_ready is 0 in FULL and 1 otherwise. It is computed from next state and registered.
- Ordering is strictly FIFO. Nothing is duplicated or dropped except on flush or reset.
- id_* fields are pure slices of the head entry and are held stable while id_valid && !id_ready.
- Flush:
  - The next state is EMPTY and id_valid=0 on the next cycle.
  - A same-cycle accept is discarded; flush wins.
  - A same-cycle consume is still considered taken by decode.
  - if_ready=1 after flush.
- When id_valid=0, data outputs keep their last value. Decode must ignore them.
- if_valid=1 with if_ready=0 is legal. Fetch must hold its data stable.

Optional Feature:
- ID_STALL_CNT_EN defined:
  - stall_cnt increments each cycle id_valid && !id_ready. It saturates at 0xFFFFFFFF.
  - It is cleared by reset only, not by flush.
- ID_STALL_CNT_EN undefined: the stall_cnt port and its logic are absent.

Decomposition:
- Package kgp_isa_pkg holds:
  - field position constants OPC_HI/LO, RS_HI/LO, RT_HI/LO, FUNCT_HI/LO, IMM_HI/LO;
  - NOP_INSTR = 32'h0000_0000;
  - a typedef for the {pc, instr} entry.
- Sub-module kgp_skid_buf: a generic 2-entry valid/ready skid buffer over a payload width.
  - id_stage_reg instantiates it for the {pc, instr} payload and adds field slicing, flush and the stall counter.

Test Plan:
- Basic accept: id_ready=1, send instr 32'h8C41_8002, pc 0x40. Next cycle id_valid=1, id_opcode=6'h23, id_rs=2, id_rt=1, id_imm16=16'h8002, id_pc=0x40.
- Streaming: 8 back-to-back instructions with id_ready=1. One accepted per cycle, outputs in order, if_ready stays 1.
- Backpressure: id_ready=0 and send A, B. After that if_ready=0 and C is held. Raise id_ready: outputs A, B, C in order, with no loss or duplicate.
- Flush in FULL with if_valid=1 (D presented). Next cycle id_valid=0, if_ready=1, and D is not output.
- Reset mid-stream: assert rst low while FULL. After the edge id_valid=0, if_ready=1, id_imm16=0, and the buffered entries are never output.
- ID_STALL_CNT_EN: hold id_ready=0 for 5 cycles with id_valid=1. stall_cnt=5. A flush leaves it at 5; reset clears it to 0.
